// File: rtl/fb_pkg.sv
// Shared geometry defaults and FSM state types for the ping-pong frame buffer controller.
package fb_pkg;

    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int PIXELS_DEF     = IMG_WIDTH_DEF * IMG_HEIGHT_DEF;
    localparam int PIX_W_DEF      = $clog2(PIXELS_DEF);
    localparam int ADDR_W_DEF     = PIX_W_DEF + 1;
    localparam int DROP_W         = 16;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } writer_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_SCAN  = 2'd1,
        R_DRAIN = 2'd2
    } reader_state_t;

endpackage

// File: rtl/fb_pingpong_ctrl_if.sv
// Camera, RAM and output-stream signals of the ping-pong controller.
// master = controller side, slave = environment side.
interface fb_pingpong_ctrl_if
    import fb_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    localparam int PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int PIX_W  = $clog2(PIXELS);
    localparam int ADDR_W = PIX_W + 1;
    localparam int HC_W   = $clog2(IMG_WIDTH);
    localparam int VC_W   = $clog2(IMG_HEIGHT);

    logic                  cam_valid;
    logic                  cam_sof;
    logic [DATA_WIDTH-1:0] cam_data;
    logic                  mem_wr_en;
    logic [ADDR_W-1:0]     mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  rd_start;
    logic                  rd_empty;
    logic                  rd_busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [HC_W-1:0]       out_hcount;
    logic [VC_W-1:0]       out_vcount;
    logic                  out_eof;
    logic [DROP_W-1:0]     drop_cnt;

    modport master (
        input  cam_valid, cam_sof, cam_data, mem_rd_data, rd_start, out_ready,
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
               rd_empty, rd_busy, out_valid, out_data, out_hcount, out_vcount,
               out_eof, drop_cnt
    );

    modport slave (
        output cam_valid, cam_sof, cam_data, mem_rd_data, rd_start, out_ready,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
               rd_empty, rd_busy, out_valid, out_data, out_hcount, out_vcount,
               out_eof, drop_cnt
    );

endinterface

// File: rtl/fb_scan_counter.sv
// Raster scan counter: linear pixel index plus column/row, wrapping to 0 after the last pixel.
// clear and inc together yield index 1 (pixel 0 consumed in the same cycle).
module fb_scan_counter
    import fb_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    localparam int PIXELS    = IMG_WIDTH * IMG_HEIGHT,
    localparam int PIX_W     = $clog2(PIXELS),
    localparam int HC_W      = $clog2(IMG_WIDTH),
    localparam int VC_W      = $clog2(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [PIX_W-1:0] idx_o,
    output logic [HC_W-1:0]  hcount_o,
    output logic [VC_W-1:0]  vcount_o,
    output logic             last_o
);

    localparam logic [PIX_W-1:0] LAST_IDX = PIX_W'(PIXELS - 1);
    localparam logic [HC_W-1:0]  LAST_HC  = HC_W'(IMG_WIDTH - 1);

    logic [PIX_W-1:0] idx_q, idx_d, base_idx_s;
    logic [HC_W-1:0]  hc_q, hc_d, base_hc_s;
    logic [VC_W-1:0]  vc_q, vc_d, base_vc_s;

    // Next position: optional clear, then optional advance with line/frame wrap.
    always_comb begin
        if (clear_i) begin
            base_idx_s = '0;
            base_hc_s  = '0;
            base_vc_s  = '0;
        end else begin
            base_idx_s = idx_q;
            base_hc_s  = hc_q;
            base_vc_s  = vc_q;
        end
        if (!inc_i) begin
            idx_d = base_idx_s;
            hc_d  = base_hc_s;
            vc_d  = base_vc_s;
        end else if (base_idx_s == LAST_IDX) begin
            idx_d = '0;
            hc_d  = '0;
            vc_d  = '0;
        end else if (base_hc_s == LAST_HC) begin
            idx_d = base_idx_s + PIX_W'(1);
            hc_d  = '0;
            vc_d  = base_vc_s + VC_W'(1);
        end else begin
            idx_d = base_idx_s + PIX_W'(1);
            hc_d  = base_hc_s + HC_W'(1);
            vc_d  = base_vc_s;
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            hc_q  <= '0;
            vc_q  <= '0;
        end else begin
            idx_q <= idx_d;
            hc_q  <= hc_d;
            vc_q  <= vc_d;
        end
    end

    assign idx_o    = idx_q;
    assign hcount_o = hc_q;
    assign vcount_o = vc_q;
    assign last_o   = (idx_q == LAST_IDX);

endmodule

// File: rtl/fb_pingpong_ctrl.sv
// Ping-pong frame buffer controller: camera writer and raster reader on opposite RAM banks.
// Define FB_DROP_CNT_EN to build the saturating dropped-frame counter on drop_cnt.
module fb_pingpong_ctrl
    import fb_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int PIXELS    = IMG_WIDTH * IMG_HEIGHT,
    localparam int PIX_W     = $clog2(PIXELS),
    localparam int HC_W      = $clog2(IMG_WIDTH),
    localparam int VC_W      = $clog2(IMG_HEIGHT)
) (
    input logic                clk,
    input logic                rst,
    fb_pingpong_ctrl_if.master bus
);

    writer_state_t    w_state_q;
    reader_state_t    r_state_q;
    logic             wr_bank_q, rd_bank_q, ready_bank_q, ready_flag_q;
    logic             out_valid_q, out_eof_q, rd_empty_q;
    logic [HC_W-1:0]  out_hcount_q;
    logic [VC_W-1:0]  out_vcount_q;

    logic             sof_hit_s, sel_bank_s, wr_bank_s, wr_fire_s, wr_en_s;
    logic             wr_restart_s, wr_complete_s, wr_overwrite_s, wr_supersede_s;
    logic             rd_take_s, rd_issue_s, rd_en_s, rd_busy_s, drop_evt_s;
    logic [PIX_W-1:0] wr_idx_s, wr_pix_s, rd_idx_s;
    logic [HC_W-1:0]  rd_hc_s, wr_hcount_unused_s;
    logic [VC_W-1:0]  rd_vc_s, wr_vcount_unused_s;
    logic             wr_last_s, rd_last_s;

    fb_scan_counter #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT)) u_wr_cnt (
        .clk(clk), .rst(rst), .clear_i(sof_hit_s), .inc_i(wr_fire_s),
        .idx_o(wr_idx_s), .hcount_o(wr_hcount_unused_s), .vcount_o(wr_vcount_unused_s),
        .last_o(wr_last_s)
    );

    fb_scan_counter #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT)) u_rd_cnt (
        .clk(clk), .rst(rst), .clear_i(rd_take_s), .inc_i(rd_issue_s),
        .idx_o(rd_idx_s), .hcount_o(rd_hc_s), .vcount_o(rd_vc_s), .last_o(rd_last_s)
    );

    assign rd_busy_s = (r_state_q != R_IDLE);

    // Bank selection and write/read/drop event decode.
    always_comb begin
        sof_hit_s = bus.cam_valid && bus.cam_sof;
        if (rd_busy_s) begin
            sel_bank_s = ~rd_bank_q;
        end else if (ready_flag_q) begin
            sel_bank_s = ~ready_bank_q;
        end else begin
            sel_bank_s = wr_bank_q;
        end
        if (w_state_q == W_IDLE) begin
            wr_fire_s = sof_hit_s;
            wr_bank_s = sel_bank_s;
        end else begin
            wr_fire_s = bus.cam_valid;
            wr_bank_s = wr_bank_q;
        end
        wr_pix_s       = sof_hit_s ? '0 : wr_idx_s;
        wr_restart_s   = (w_state_q == W_FILL) && sof_hit_s;
        wr_complete_s  = (w_state_q == W_FILL) && bus.cam_valid && !bus.cam_sof && wr_last_s;
        wr_overwrite_s = (w_state_q == W_IDLE) && sof_hit_s && ready_flag_q
                         && (sel_bank_s == ready_bank_q);
        rd_take_s      = (r_state_q == R_IDLE) && bus.rd_start && ready_flag_q;
        // A completion racing a start is not a drop: the reader takes the older frame.
        wr_supersede_s = wr_complete_s && ready_flag_q && !rd_take_s;
        drop_evt_s     = wr_restart_s || wr_overwrite_s || wr_supersede_s;
        rd_issue_s     = (r_state_q == R_SCAN) && (!out_valid_q || bus.out_ready);
    end

    // Writer FSM and the ready-frame hand-off flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q    <= W_IDLE;
            wr_bank_q    <= 1'b0;
            ready_bank_q <= 1'b0;
            ready_flag_q <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (sof_hit_s) begin
                        wr_bank_q <= sel_bank_s;
                        w_state_q <= W_FILL;
                    end
                end
                W_FILL: begin
                    if (wr_complete_s) begin
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
            if (wr_complete_s) begin
                ready_bank_q <= wr_bank_q;
                ready_flag_q <= 1'b1;
            end else if (rd_take_s || wr_overwrite_s) begin
                ready_flag_q <= 1'b0;
            end
        end
    end

    // Reader FSM; position/eof register with each issue so they line up with RAM data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= R_IDLE;
            rd_bank_q    <= 1'b0;
            rd_empty_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_eof_q    <= 1'b0;
            out_hcount_q <= '0;
            out_vcount_q <= '0;
        end else begin
            rd_empty_q <= 1'b0;
            case (r_state_q)
                R_IDLE: begin
                    if (bus.rd_start) begin
                        if (ready_flag_q) begin
                            rd_bank_q <= ready_bank_q;
                            r_state_q <= R_SCAN;
                        end else begin
                            rd_empty_q <= 1'b1;
                        end
                    end
                end
                R_SCAN: begin
                    if (rd_issue_s) begin
                        out_valid_q  <= 1'b1;
                        out_hcount_q <= rd_hc_s;
                        out_vcount_q <= rd_vc_s;
                        out_eof_q    <= rd_last_s;
                        if (rd_last_s) begin
                            r_state_q <= R_DRAIN;
                        end
                    end
                end
                R_DRAIN: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q  <= 1'b0;
                        out_eof_q    <= 1'b0;
                        out_hcount_q <= '0;
                        out_vcount_q <= '0;
                        r_state_q    <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign wr_en_s         = wr_fire_s && !rst;
    assign rd_en_s         = rd_issue_s && !rst;
    assign bus.mem_wr_en   = wr_en_s;
    assign bus.mem_wr_addr = wr_en_s ? {wr_bank_s, wr_pix_s} : '0;
    assign bus.mem_wr_data = wr_en_s ? bus.cam_data : '0;
    assign bus.mem_rd_en   = rd_en_s;
    assign bus.mem_rd_addr = rd_en_s ? {rd_bank_q, rd_idx_s} : '0;
    assign bus.rd_empty    = rd_empty_q;
    assign bus.rd_busy     = rd_busy_s;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_valid_q ? bus.mem_rd_data : '0;
    assign bus.out_hcount  = out_hcount_q;
    assign bus.out_vcount  = out_vcount_q;
    assign bus.out_eof     = out_eof_q;

`ifdef FB_DROP_CNT_EN
    logic [DROP_W-1:0] drop_cnt_q;

    // Saturating dropped-frame counter; at most one drop event exists per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop_evt_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_q <= drop_cnt_q;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    logic drop_evt_unused_s;
    assign drop_evt_unused_s = drop_evt_s;
    assign bus.drop_cnt      = 16'h0000;
`endif

endmodule

// File: tb/tb_fb_pingpong_ctrl.sv
// Scoreboard bench for fb_pingpong_ctrl on a small 8x4 frame with a behavioural dual-port RAM.
module tb_fb_pingpong_ctrl;
    import fb_pkg::*;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int DW  = 8;
    localparam int PIX = W * H;
    localparam int PW  = $clog2(PIX);
    localparam int AW  = PW + 1;
    localparam int HCW = $clog2(W);
    localparam int VCW = $clog2(H);
`ifdef FB_DROP_CNT_EN
    localparam int DROP_EN = 1;
`else
    localparam int DROP_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fb_pingpong_ctrl_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW)) bus ();

    fb_pingpong_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] ram [0:2*PIX-1];
    always @(posedge clk) begin
        if (bus.mem_wr_en === 1'b1) ram[bus.mem_wr_addr] <= bus.mem_wr_data;
        if (bus.mem_rd_en === 1'b1) bus.mem_rd_data <= ram[bus.mem_rd_addr];
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [HCW-1:0] h;
        logic [VCW-1:0] v;
        logic           eof;
    } rd_exp_t;

    wr_exp_t exp_wr[$];
    rd_exp_t exp_rd[$];
    int total = 0;
    int bad   = 0;
    int rdy_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int f, input int i);
        return DW'((f * 37 + i * 5 + 3) % 256);
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, bus.mem_rd_en,
                    bus.mem_rd_addr, bus.rd_empty, bus.rd_busy, bus.out_valid, bus.out_data,
                    bus.out_hcount, bus.out_vcount, bus.out_eof, bus.drop_cnt});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_frame(input int f, input int bank, input int npix);
        wr_exp_t e;
        for (int i = 0; i < npix; i++) begin
            if (i % 7 == 6) begin
                bus.cam_valid = 1'b0;
                bus.cam_sof   = 1'b0;
                tick();
            end
            bus.cam_valid = 1'b1;
            bus.cam_sof   = (i == 0);
            bus.cam_data  = pix(f, i);
            e.addr = {bank[0], PW'(i)};
            e.data = pix(f, i);
            exp_wr.push_back(e);
            tick();
        end
        bus.cam_valid = 1'b0;
        bus.cam_sof   = 1'b0;
    endtask

    task automatic expect_frame(input int f);
        rd_exp_t e;
        for (int i = 0; i < PIX; i++) begin
            e.data = pix(f, i);
            e.h    = HCW'(i % W);
            e.v    = VCW'(i / W);
            e.eof  = (i == PIX - 1);
            exp_rd.push_back(e);
        end
    endtask

    task automatic start_read();
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((bus.rd_busy || exp_rd.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("scan_done_in_budget", 64'(n < budget), 64'd1);
    endtask

    task automatic expect_empty(input string tag);
        bus.rd_start = 1'b1;
        @(negedge clk);
        check({tag, "_rden_c0"}, 64'(bus.mem_rd_en), 64'd0);
        tick();
        bus.rd_start = 1'b0;
        @(negedge clk);
        check({tag, "_empty_pulse"}, 64'(bus.rd_empty), 64'd1);
        check({tag, "_not_busy"}, 64'(bus.rd_busy), 64'd0);
        check({tag, "_rden_c1"}, 64'(bus.mem_rd_en), 64'd0);
        tick();
        @(negedge clk);
        check({tag, "_empty_end"}, 64'(bus.rd_empty), 64'd0);
        tick();
    endtask

    task automatic check_drop(input string tag, input int n);
        @(negedge clk);
        check(tag, 64'(bus.drop_cnt), (DROP_EN != 0) ? 64'(n) : 64'd0);
        tick();
    endtask

    // out_ready driver
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // write monitor
    initial begin
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_wr_en === 1'b1) begin
                check("wr_expected_present", 64'(exp_wr.size() > 0), 64'd1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 64'(bus.mem_wr_addr), 64'(e.addr));
                    check("wr_data", 64'(bus.mem_wr_data), 64'(e.data));
                end
            end
        end
    end

    // output stream monitor
    initial begin
        rd_exp_t e;
        logic hold_pend;
        logic [DW-1:0] hold_data;
        hold_pend = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (hold_pend) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_data", 64'(bus.out_data), 64'(hold_data));
            end
            hold_pend = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
            hold_data = bus.out_data;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                check("rd_expected_present", 64'(exp_rd.size() > 0), 64'd1);
                if (exp_rd.size() > 0) begin
                    e = exp_rd.pop_front();
                    check("out_data", 64'(bus.out_data), 64'(e.data));
                    check("out_hcount", 64'(bus.out_hcount), 64'(e.h));
                    check("out_vcount", 64'(bus.out_vcount), 64'(e.v));
                    check("out_eof", 64'(bus.out_eof), 64'(e.eof));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.cam_valid = 1'b0;
        bus.cam_sof   = 1'b0;
        bus.cam_data  = '0;
        bus.rd_start  = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", all_outs(), 64'd0);

        // pixels without sof are ignored while idle
        tick();
        bus.cam_valid = 1'b1;
        bus.cam_sof   = 1'b0;
        bus.cam_data  = 8'hAA;
        @(negedge clk);
        check("stray_pixel_a", 64'(bus.mem_wr_en), 64'd0);
        tick();
        @(negedge clk);
        check("stray_pixel_b", 64'(bus.mem_wr_en), 64'd0);
        tick();
        bus.cam_valid = 1'b0;

        expect_empty("empty0");
        while ($time < 100) tick();

        // frame 0 into bank 0, then read it with out_ready held high
        write_frame(0, 0, PIX);
        check_drop("drop_after_f0", 0);
        expect_frame(0);
        bus.rd_start = 1'b1;
        @(negedge clk);
        check("lat_c0_valid", 64'(bus.out_valid), 64'd0);
        tick();
        bus.rd_start = 1'b0;
        @(negedge clk);
        check("lat_c1_valid", 64'(bus.out_valid), 64'd0);
        check("lat_c1_rden", 64'(bus.mem_rd_en), 64'd1);
        check("lat_c1_rdaddr", 64'(bus.mem_rd_addr), 64'd0);
        @(negedge clk);
        check("lat_c2_valid", 64'(bus.out_valid), 64'd1);
        repeat (PIX - 1) @(negedge clk);
        check("last_beat_eof", 64'(bus.out_eof), 64'd1);
        check("last_beat_busy", 64'(bus.rd_busy), 64'd1);
        @(negedge clk);
        check("busy_after_last", 64'(bus.rd_busy), 64'd0);
        check("valid_after_last", 64'(bus.out_valid), 64'd0);
        tick();

        // frame 1 to bank 0; frame 2 written to bank 1 while bank 0 is scanned with random ready
        write_frame(1, 0, PIX);
        expect_frame(1);
        rdy_mode = 1;
        start_read();
        fork
            write_frame(2, 1, PIX);
            wait_idle(400);
        join
        rdy_mode = 0;
        tick();

        // frame 3 supersedes unread frame 2 and lands back in bank 0
        write_frame(3, 0, PIX);
        check_drop("drop_supersede", 1);
        expect_frame(3);
        start_read();
        wait_idle(200);

        // partial frame 4 restarted by frame 5's sof in the same bank
        write_frame(4, 0, 10);
        write_frame(5, 0, PIX);
        check_drop("drop_restart", 2);
        expect_frame(5);
        rdy_mode = 1;
        start_read();
        wait_idle(400);
        rdy_mode = 0;
        tick();

        // reset in the middle of a scan and of a write
        write_frame(6, 0, PIX);
        expect_frame(6);
        start_read();
        repeat (4) tick();
        write_frame(7, 1, 3);
        rst = 1'b1;
        tick();
        exp_rd.delete();
        @(negedge clk);
        check("rst_midscan_outputs", all_outs(), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        expect_empty("empty_after_rst");

        check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_pingpong_ctrl.md
Name: fb_pingpong_ctrl

Overview:
Double-buffer (ping-pong) controller for the camera frame buffer: it sequences camera pixel writes into one bank while a display/processing reader scans the other. It generates bank-qualified write/read addresses for an external dual-port RAM of depth 2*PIXELS with 1-cycle read latency. It owns bank hand-off between writer and reader, so the reader never sees a frame that is still being written.

Parameters:
IMG_WIDTH, 640, pixels per line
IMG_HEIGHT, 480, lines per frame
DATA_WIDTH, 8, pixel width
(derived) PIXELS = IMG_WIDTH*IMG_HEIGHT; PIX_W = $clog2(PIXELS); ADDR_W = PIX_W+1 (MSB = bank)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cam_valid  in  1  camera pixel valid (one pixel per asserted cycle)
- cam_sof  in  1  qualifies the first pixel of a frame (with cam_valid)
- cam_data  in  DATA_WIDTH  camera pixel
- mem_wr_en  out  1  RAM write enable
- mem_wr_addr  out  ADDR_W  {wr_bank, pixel index}
- mem_wr_data  out  DATA_WIDTH  RAM write data
- mem_rd_en  out  1  RAM read enable; RAM output holds while low
- mem_rd_addr  out  ADDR_W  {rd_bank, pixel index}
- mem_rd_data  in  DATA_WIDTH  RAM read data, valid 1 cycle after mem_rd_en
- rd_start  in  1  pulse: request a scan of the newest complete frame
- rd_empty  out  1  1-cycle pulse: rd_start rejected, no frame ready
- rd_busy  out  1  reader scanning or draining
- out_valid / out_ready  out / in  1  output stream handshake
- out_data  out  DATA_WIDTH  = mem_rd_data
- out_hcount  out  $clog2(IMG_WIDTH)  pixel column
- out_vcount  out  $clog2(IMG_HEIGHT)  pixel row
- out_eof  out  1  with out_valid on last pixel (index PIXELS-1)
- drop_cnt  out  16  frames dropped (see Optional Feature)

Behaviour:
- Reset: all outputs 0; writer W_IDLE, reader R_IDLE, wr_bank=rd_bank=ready_bank=0, ready_flag=0, counters 0. A rst mid-frame aborts both sides; no partial frame is marked ready.
- Writer FSM W_IDLE/W_FILL:
  - W_IDLE: cam_valid&&cam_sof selects the bank: rd_busy ? ~rd_bank : (ready_flag ? ~ready_bank : wr_bank). It then writes pixel 0 and goes to W_FILL. Pixels without sof are ignored.
  - W_FILL: each cam_valid writes combinationally (mem_wr_en=cam_valid, addr={wr_bank,idx}), then idx++. After writing idx PIXELS-1: ready_bank<=wr_bank, ready_flag<=1, go to W_IDLE.
  - sof in W_FILL: restart at idx 0 in the same bank; the partial frame is discarded and counted as a drop.
- Frame overwrite: if sof selects a bank equal to ready_bank while ready_flag=1 (reader busy on the other bank), clear ready_flag and count a drop. If completion supersedes an unread ready frame, count a drop.
- Reader FSM R_IDLE/R_SCAN/R_DRAIN:
  - R_IDLE + rd_start: if ready_flag then rd_bank<=ready_bank, ready_flag<=0, go to R_SCAN; else pulse rd_empty next cycle and stay.
  - R_SCAN: mem_rd_en = !out_valid || out_ready. Each issue increments idx/hcount/vcount. out_valid is set the cycle after an issue and cleared on accept with no new issue. After issuing PIXELS-1, go to R_DRAIN.
  - R_DRAIN: go to R_IDLE when the last pixel is accepted. rd_start is ignored while rd_busy.
  - out_hcount/out_vcount/out_eof register alongside the issue, so they align with out_data.
  - Throughput: 1 pixel/cycle with out_ready held high. Latency from rd_start to first out_valid is 2 cycles.
- Simultaneous writer completion and rd_start: rd_start samples the registered ready_flag (old value). The completion then sets ready_flag/ready_bank for the next start.
- Counters wrap: hcount at IMG_WIDTH-1 → 0 with vcount++; idx is not wrap-sensitive beyond PIXELS-1.
- The writer never addresses rd_bank while rd_busy; this is an assertion target.

Optional Feature:
- FB_DROP_CNT_EN defined: drop_cnt is a 16-bit saturating counter (holds at 0xFFFF), incremented once per drop event and at most once per cycle. It clears on rst.
- Undefined: drop_cnt tied to 0 and no counter logic.

Decomposition:
- Package fb_pkg: IMG_WIDTH/IMG_HEIGHT/PIXELS defaults, PIX_W/ADDR_W localparams, writer_state_t {W_IDLE,W_FILL}, reader_state_t {R_IDLE,R_SCAN,R_DRAIN}.
- Sub-module fb_scan_counter (clear/inc → idx, hcount, vcount, last), instantiated once for the writer and once for the reader.

Test Plan:
- Reset, then a full frame with sof at cycle 10 → writes go to bank 0, addr 0..307199; ready_flag=1, ready_bank=0 after the last write.
- rd_start after the frame, out_ready=1 → 307200 beats from bank 0; out_hcount/vcount 0,0 … 639,479; out_eof only on the last beat; rd_busy drops after it.
- Second frame sof while the reader scans bank 0 → writes go to bank 1; no write address ever has MSB=0 during the scan.
- rd_start with no frame written → rd_empty pulses 1 cycle; no mem_rd_en.
- out_ready toggled 1/0 randomly → no pixel lost or duplicated; out_data stable while out_valid && !out_ready.
- Two frames complete with no rd_start (FB_DROP_CNT_EN) → drop_cnt=1; mid-frame sof → drop_cnt=2; rst mid-scan → all outputs 0 next cycle.
